// File: rtl/motor_cmd_if.sv
// Command handshake bundle for motor_cmd_seq: a signed speed request
// (direction + duty) offered with valid/ready.
interface motor_cmd_if #(
    parameter int unsigned DUTY_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_dir;
    logic [DUTY_W-1:0] cmd_duty;

    modport master (output cmd_valid, output cmd_dir, output cmd_duty, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_dir, input  cmd_duty, output cmd_ready);
endinterface

// File: rtl/motor_cmd_seq.sv
// Speed/direction sequencer feeding the H-bridge selector: ramps duty, generates PWM,
// inserts a dead-time on reversal. Define MOTOR_SEQ_RAMP_EN for the stepped ramp.
module motor_cmd_seq #(
    parameter int unsigned DUTY_W   = 8,
    parameter int unsigned RAMP_DIV = 16,
    parameter int unsigned DEAD_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    motor_cmd_if.slave        cmd,
    input  logic              estop,
    output logic              pwm,
    output logic              dir,
    output logic              en,
    output logic [DUTY_W-1:0] cur_duty,
    output logic              busy
);

    if (RAMP_DIV < 1) begin : g_bad_ramp_div
        $error("motor_cmd_seq: RAMP_DIV must be >= 1");
    end
    if (DEAD_CYC < 1) begin : g_bad_dead_cyc
        $error("motor_cmd_seq: DEAD_CYC must be >= 1");
    end

    localparam int unsigned DCNT_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DEAD,
        S_FAULT
    } state_e;

    state_e              state_q, state_d;
    logic                tgt_dir_q, tgt_dir_d;
    logic [DUTY_W-1:0]   tgt_duty_q, tgt_duty_d;
    logic [DUTY_W-1:0]   cur_q, cur_d;
    logic                dir_q, dir_d;
    logic                en_q, en_d;
    logic                pwm_q, pwm_d;
    logic [DUTY_W-1:0]   pcnt_q, pcnt_d;
    logic [DUTY_W-1:0]   shadow_q, shadow_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic                ready;
    logic                accept;
    logic                dead_last;

`ifdef MOTOR_SEQ_RAMP_EN
    localparam int unsigned RCNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
    logic                tick;

    assign tick = (rcnt_q == RCNT_W'(RAMP_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rcnt_q <= '0;
        else        rcnt_q <= rcnt_d;
    end
`endif

    assign ready     = !((state_q == S_DEAD) || (state_q == S_FAULT));
    assign accept    = cmd.cmd_valid & ready;
    assign dead_last = (dcnt_q == DCNT_W'(DEAD_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tgt_dir_q  <= 1'b0;
            tgt_duty_q <= '0;
            cur_q      <= '0;
            dir_q      <= 1'b0;
            en_q       <= 1'b0;
            pwm_q      <= 1'b0;
            pcnt_q     <= '0;
            shadow_q   <= '0;
            dcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            tgt_dir_q  <= tgt_dir_d;
            tgt_duty_q <= tgt_duty_d;
            cur_q      <= cur_d;
            dir_q      <= dir_d;
            en_q       <= en_d;
            pwm_q      <= pwm_d;
            pcnt_q     <= pcnt_d;
            shadow_q   <= shadow_d;
            dcnt_q     <= dcnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tgt_dir_d  = tgt_dir_q;
        tgt_duty_d = tgt_duty_q;
        cur_d      = cur_q;
        dir_d      = dir_q;
        dcnt_d     = '0;
`ifdef MOTOR_SEQ_RAMP_EN
        rcnt_d     = '0;
`endif

        if (accept) begin
            tgt_dir_d  = cmd.cmd_dir;
            tgt_duty_d = cmd.cmd_duty;
        end

        case (state_q)
            S_IDLE: begin
                cur_d = '0;
                if (tgt_duty_q != '0) begin
                    dir_d   = tgt_dir_q;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
`ifdef MOTOR_SEQ_RAMP_EN
                rcnt_d = tick ? '0 : rcnt_q + 1'b1;
                if (tick) begin
                    if (tgt_dir_q == dir_q) begin
                        if (cur_q < tgt_duty_q)      cur_d = cur_q + 1'b1;
                        else if (cur_q > tgt_duty_q) cur_d = cur_q - 1'b1;
                    end else if (cur_q != '0) begin
                        cur_d = cur_q - 1'b1;
                    end
                end
`else
                cur_d = (tgt_dir_q == dir_q) ? tgt_duty_q : '0;
`endif
                if (cur_q == '0 && tgt_duty_q == '0)
                    state_d = S_IDLE;
                else if (cur_q == '0 && tgt_dir_q != dir_q)
                    state_d = S_DEAD;
            end
            S_DEAD: begin
                cur_d  = '0;
                dcnt_d = dcnt_q + 1'b1;
                if (dead_last) begin
                    dir_d   = tgt_dir_q;
                    state_d = (tgt_duty_q == '0) ? S_IDLE : S_RUN;
                end
            end
            S_FAULT: begin
                cur_d      = '0;
                tgt_duty_d = '0;
                if (!estop) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // estop wins over everything, including a command accepted this same cycle
        if (estop) begin
            state_d    = S_FAULT;
            cur_d      = '0;
            tgt_duty_d = '0;
            dir_d      = dir_q;
        end
    end

    // PWM compares the next counter value so pwm, en and the period boundary line up
    always_comb begin
        en_d     = (state_d == S_RUN);
        pcnt_d   = pcnt_q + 1'b1;
        shadow_d = (pcnt_q == '1) ? cur_q : shadow_q;
        pwm_d    = en_d & (pcnt_d < shadow_d);
    end

    assign cmd.cmd_ready = ready;
    assign pwm           = pwm_q;
    assign dir           = dir_q;
    assign en            = en_q;
    assign cur_duty      = cur_q;
    assign busy          = (state_q != S_IDLE) || (cur_q != tgt_duty_q);

endmodule

// File: tb/tb_motor_cmd_seq.sv
// Directed bench for motor_cmd_seq (DUTY_W=8, RAMP_DIV=16, DEAD_CYC=64); handles
// either build of MOTOR_SEQ_RAMP_EN.
module tb_motor_cmd_seq;

    localparam int DW = 8;
`ifdef MOTOR_SEQ_RAMP_EN
    localparam int RAMP_UP_CYC = 64;
`else
    localparam int RAMP_UP_CYC = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          estop;
    logic          pwm, dir, en, busy;
    logic [DW-1:0] cur_duty;

    motor_cmd_if #(.DUTY_W(DW)) cmd_if ();

    motor_cmd_seq #(.DUTY_W(DW), .RAMP_DIV(16), .DEAD_CYC(64)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd_if), .estop(estop),
        .pwm(pwm), .dir(dir), .en(en), .cur_duty(cur_duty), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int v, d, duty, es, cyc;
        int e_en, e_dir, e_cur, e_rdy, e_busy;
    } vec_t;

    vec_t vt[$];
    int   total = 0;
    int   bad   = 0;
    int   glitch = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_mon();
        logic pe, pd;
        pe = en;
        pd = dir;
        step();
        if (pe && dir != pd) glitch++;
    endtask

    task automatic send(input int d, input int duty);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_dir   = 1'(d);
        cmd_if.cmd_duty  = DW'(duty);
        step_mon();
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pwm"},  int'(pwm), 0);
        chk({tag, "_en"},   int'(en), 0);
        chk({tag, "_dir"},  int'(dir), 0);
        chk({tag, "_cur"},  int'(cur_duty), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_rdy"},  int'(cmd_if.cmd_ready), 1);
    endtask

    initial begin
        int n, cnt, cnt2, en_lo, low, rdy_hi, cur16, found;
        logic prev;

        // v, d, duty, es, cyc  |  en, dir, cur, rdy, busy
        vt.push_back('{0, 0, 0, 0, 3,   0, 0, 0, 1, 0});
        vt.push_back('{1, 1, 4, 0, 1,   0, 0, 0, 1, 1});
        vt.push_back('{0, 0, 0, 0, 1,   1, 1, 0, 1, 1});
        vt.push_back('{0, 0, 0, 1, 1,   0, 1, 0, 0, 1});
        vt.push_back('{1, 0, 9, 1, 2,   0, 1, 0, 0, 1});
        vt.push_back('{0, 0, 0, 0, 1,   0, 1, 0, 1, 0});
        vt.push_back('{0, 0, 0, 0, 5,   0, 1, 0, 1, 0});
        vt.push_back('{1, 0, 0, 0, 1,   0, 1, 0, 1, 0});
        vt.push_back('{0, 0, 0, 0, 2,   0, 1, 0, 1, 0});
        vt.push_back('{1, 1, 7, 1, 1,   0, 1, 0, 0, 1});
        vt.push_back('{0, 0, 0, 0, 1,   0, 1, 0, 1, 0});
        vt.push_back('{0, 0, 0, 0, 3,   0, 1, 0, 1, 0});

        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_dir   = 1'b0;
        cmd_if.cmd_duty  = '0;
        estop = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_reset_vals("por");
        step();
        step();
        rst_n = 1'b1;
        step();

        foreach (vt[i]) begin
            cmd_if.cmd_valid = 1'(vt[i].v);
            cmd_if.cmd_dir   = 1'(vt[i].d);
            cmd_if.cmd_duty  = DW'(vt[i].duty);
            estop            = 1'(vt[i].es);
            repeat (vt[i].cyc) step();
            chk($sformatf("vec%0d_en", i),   int'(en), vt[i].e_en);
            chk($sformatf("vec%0d_dir", i),  int'(dir), vt[i].e_dir);
            chk($sformatf("vec%0d_cur", i),  int'(cur_duty), vt[i].e_cur);
            chk($sformatf("vec%0d_rdy", i),  int'(cmd_if.cmd_ready), vt[i].e_rdy);
            chk($sformatf("vec%0d_busy", i), int'(busy), vt[i].e_busy);
            chk($sformatf("vec%0d_pwm", i),  int'(pwm), 0);
        end
        cmd_if.cmd_valid = 1'b0;
        estop = 1'b0;

        // ramp up from IDLE to duty 4 forward
        send(1, 4);
        step();
        chk("run_entry_en", int'(en), 1);
        chk("run_entry_dir", int'(dir), 1);
        n = 0; cur16 = -1; en_lo = 0;
        while (cur_duty != 8'd4 && n < 300) begin
            step();
            n++;
            if (n == 16) cur16 = int'(cur_duty);
            if (!en) en_lo++;
        end
        chk("ramp_up_cycles", n, RAMP_UP_CYC);
`ifdef MOTOR_SEQ_RAMP_EN
        chk("ramp_cur_at16", cur16, 1);
`endif
        chk("ramp_up_en_held", en_lo, 0);
        repeat (256) step();
        cnt = 0;
        repeat (256) begin
            step();
            cnt += int'(pwm);
        end
        chk("pwm_high_duty4", cnt, 4);
        chk("cur_saturated", int'(cur_duty), 4);

        // duty change mid-period only takes effect after the wrap
        found = 0;
        for (int i = 0; i < 600 && found == 0; i++) begin
            prev = pwm;
            step();
            if (!prev && pwm) found = 1;
        end
        chk("pwm_rise_found", found, 1);
        cnt = int'(pwm); en_lo = 0;
        for (int p = 1; p < 256; p++) begin
            step();
            cnt += int'(pwm);
            if (!en) en_lo++;
            if (p == 100) begin
                cmd_if.cmd_valid = 1'b1;
                cmd_if.cmd_dir   = 1'b1;
                cmd_if.cmd_duty  = 8'd6;
            end else if (p == 101) begin
                cmd_if.cmd_valid = 1'b0;
            end
        end
        chk("pwm_old_period", cnt, 4);
        cnt2 = 0;
        for (int p = 0; p < 256; p++) begin
            step();
            cnt2 += int'(pwm);
            if (!en) en_lo++;
        end
        chk("pwm_new_period", cnt2, 6);
        chk("retarget_no_dead", en_lo, 0);
        chk("retarget_cur", int'(cur_duty), 6);

        // reversal: ramp down, dead-time, flip, ramp up
        glitch = 0;
        send(0, 4);
        n = 0;
        while (en && n < 300) begin
            step_mon();
            n++;
        end
        chk("rev_reach_dead", int'(en), 0);
        chk("rev_cur_at_dead", int'(cur_duty), 0);
        chk("rev_dir_before", int'(dir), 1);
        low = 0; rdy_hi = 0;
        while (!en && low < 300) begin
            low++;
            if (cmd_if.cmd_ready) rdy_hi++;
            step_mon();
        end
        chk("dead_len", low, 64);
        chk("dead_ready_low", rdy_hi, 0);
        chk("rev_dir_after", int'(dir), 0);
        n = 0;
        while (cur_duty != 8'd4 && n < 300) begin
            step_mon();
            n++;
        end
        chk("rev_ramp_up_cycles", n, RAMP_UP_CYC);
        chk("dir_change_en_hi", glitch, 0);

        // async reset in the middle of a dead-time
        send(1, 3);
        n = 0;
        while (cmd_if.cmd_ready && n < 300) begin
            step();
            n++;
        end
        chk("dead2_ready", int'(cmd_if.cmd_ready), 0);
        chk("dead2_en", int'(en), 0);
        repeat (10) step();
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("rst_dead");
        #2 rst_n = 1'b1;
        repeat (3) step();
        chk("post_rst_rdy", int'(cmd_if.cmd_ready), 1);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_en", int'(en), 0);

        // estop mid-ramp
        send(1, 8);
        repeat (40) step();
        chk("estop_pre_cur_nz", int'(cur_duty != '0), 1);
        estop = 1'b1;
        step();
        chk("estop_en", int'(en), 0);
        chk("estop_pwm", int'(pwm), 0);
        chk("estop_cur", int'(cur_duty), 0);
        chk("estop_rdy", int'(cmd_if.cmd_ready), 0);
        estop = 1'b0;
        step();
        chk("estop_rel_rdy", int'(cmd_if.cmd_ready), 1);
        chk("estop_rel_busy", int'(busy), 0);
        cnt = 0;
        repeat (20) begin
            step();
            cnt += int'(pwm) + int'(en) + int'(cur_duty);
        end
        chk("estop_quiet", cnt, 0);

        // async reset while running forward
        send(1, 5);
        repeat (30) step();
        chk("run2_en", int'(en), 1);
        chk("run2_dir", int'(dir), 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("rst_run");
        #2 rst_n = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
